// File: rtl/qei_readout_sched.sv
// qei_readout_sched: sequencer between the QEI counter core and the host byte port.
//   - On rd_req, takes an atomic 16-bit snapshot of count_in and streams it as
//     two bytes (LSB first) over a valid/ready port (out_data/out_valid/out_last/out_ready).
//   - Independently runs a programmable sampling window and reports the signed
//     count delta per window on vel, with a one-cycle vel_valid pulse.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ena               global enable; 0 freezes every register
//   count_in, dir_in  live position count and direction from the QEI core
//   period_in         window length minus 1 (clk cycles)
//   rd_req            one-cycle snapshot request
//   out_ready         byte consumer ready
//   ov_clr            clears overrun (and sat_flag when present)
//   out_data/out_valid/out_last  streamed byte, valid, final-byte marker
//   busy, snap_dir    readout in progress, direction captured with the snapshot
//   vel, vel_valid    delta of last completed window, update pulse
//   overrun           sticky: rd_req arrived while busy
// Optional feature macro: QEI_VEL_SAT_EN -- signed saturating velocity plus a
// sticky sat_flag output.
module qei_readout_sched #(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [15:0]         count_in,
  input  logic                dir_in,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic                rd_req,
  input  logic                out_ready,
  input  logic                ov_clr,
  output logic [7:0]          out_data,
  output logic                out_valid,
  output logic                out_last,
  output logic                busy,
  output logic                snap_dir,
  output logic [15:0]         vel,
  output logic                vel_valid,
`ifdef QEI_VEL_SAT_EN
  output logic                overrun,
  output logic                sat_flag
`else
  output logic                overrun
`endif
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  state_t              state;
  logic [BYTE_W-1:0]   snap_hi;
  logic [PERIOD_W-1:0] timer;
  logic [PERIOD_W-1:0] period_q;
  logic [CNT_W-1:0]    prev_count;
  logic                primed;
  logic                terminal;
  logic [CNT_W-1:0]    vel_next;

  // Readout FSM: the low byte goes straight into out_data at capture time, so
  // only the high byte of the snapshot needs to be kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      snap_hi   <= '0;
      snap_dir  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else if (ena) begin
      // A request seen in any non-IDLE state, including the final handshake
      // cycle, is dropped and flagged; set beats clear.
      if (rd_req && (state != IDLE)) begin
        overrun <= 1'b1;
      end else if (ov_clr) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rd_req) begin
            snap_hi   <= count_in[CNT_W-1:BYTE_W];
            snap_dir  <= dir_in;
            out_data  <= count_in[BYTE_W-1:0];
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (out_ready) begin
            out_data <= snap_hi;
            out_last <= 1'b1;
            state    <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Window terminal count; period_q is reloaded at each window start.
  assign terminal = (timer == period_q);

`ifdef QEI_VEL_SAT_EN
  logic [CNT_W:0] diff_ext;
  logic           sat_hit;

  // Signed difference of sign-extended counts, clamped to the 16-bit range.
  always_comb begin
    diff_ext = {count_in[CNT_W-1], count_in} - {prev_count[CNT_W-1], prev_count};
    sat_hit  = (diff_ext[CNT_W] != diff_ext[CNT_W-1]);
    vel_next = diff_ext[CNT_W-1:0];
    if (sat_hit) begin
      vel_next = diff_ext[CNT_W] ? 16'h8000 : 16'h7FFF;
    end
  end

  // Sticky saturation indicator; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (ena) begin
      if (terminal && primed && sat_hit) begin
        sat_flag <= 1'b1;
      end else if (ov_clr) begin
        sat_flag <= 1'b0;
      end
    end
  end
`else
  // Plain modulo-2^16 delta; two's complement gives the signed result.
  always_comb begin
    vel_next = count_in - prev_count;
  end
`endif

  // Velocity window: the first terminal after reset only primes prev_count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= '0;
      period_q   <= '0;
      prev_count <= '0;
      primed     <= 1'b0;
      vel        <= '0;
      vel_valid  <= 1'b0;
    end else if (ena) begin
      vel_valid <= 1'b0;
      if (terminal) begin
        timer      <= '0;
        period_q   <= period_in;
        prev_count <= count_in;
        primed     <= 1'b1;
        if (primed) begin
          vel       <= vel_next;
          vel_valid <= 1'b1;
        end
      end else begin
        timer <= timer + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_qei_readout_sched.sv
// Directed self-checking bench for qei_readout_sched (default build).
module tb_qei_readout_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [15:0] count_in;
  logic        dir_in;
  logic [15:0] period_in;
  logic        rd_req;
  logic        out_ready;
  logic        ov_clr;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        busy;
  logic        snap_dir;
  logic [15:0] vel;
  logic        vel_valid;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qei_readout_sched #(.PERIOD_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .count_in  (count_in),
    .dir_in    (dir_in),
    .period_in (period_in),
    .rd_req    (rd_req),
    .out_ready (out_ready),
    .ov_clr    (ov_clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy),
    .snap_dir  (snap_dir),
    .vel       (vel),
    .vel_valid (vel_valid),
    .overrun   (overrun)
  );

  typedef struct {
    logic [15:0] count;
    logic        dir;
    logic [7:0]  lo;
    logic [7:0]  hi;
  } rd_vec_t;

  typedef struct {
    logic [15:0] count;
    logic        chk;
    logic [15:0] exp_vel;
  } vel_vec_t;

  rd_vec_t  rv [4];
  vel_vec_t vv [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for a vel_valid pulse; returns the number of ticks taken, 0 on timeout.
  task automatic wait_vel(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (vel_valid) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int first_pulse;
    int last_pulse;
    int npulses;
    int n;

    rv[0] = '{16'h1234, 1'b1, 8'h34, 8'h12};
    rv[1] = '{16'h0000, 1'b0, 8'h00, 8'h00};
    rv[2] = '{16'hFFFF, 1'b1, 8'hFF, 8'hFF};
    rv[3] = '{16'hA5C3, 1'b0, 8'hC3, 8'hA5};

    vv[0] = '{16'hFFFE, 1'b0, 16'h0000};
    vv[1] = '{16'h0003, 1'b1, 16'h0005};
    vv[2] = '{16'hFFFE, 1'b1, 16'hFFFB};
    vv[3] = '{16'h8000, 1'b1, 16'h8002};
    vv[4] = '{16'h7FFF, 1'b1, 16'hFFFF};
    vv[5] = '{16'h7FFF, 1'b1, 16'h0000};

    rst_n = 1'b0; ena = 1'b1; count_in = 16'h0100; dir_in = 1'b0;
    period_in = 16'd9; rd_req = 1'b0; out_ready = 1'b1; ov_clr = 1'b0;
    repeat (2) tick();

    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_vel", 32'(vel), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;

    // Velocity window, period 9 and count +1 per cycle.
    first_pulse = 0; last_pulse = 0; npulses = 0;
    for (int t = 1; t <= 45; t++) begin
      tick();
      count_in = count_in + 16'd1;
      if (t == 1) begin
        check("prime_no_valid", 32'(vel_valid), 32'h0);
        check("prime_vel_hold", 32'(vel), 32'h0);
      end
      if (vel_valid) begin
        npulses++;
        check("win_vel", 32'(vel), 32'd10);
        if (first_pulse == 0) first_pulse = t;
        else check("win_spacing", 32'(t - last_pulse), 32'd10);
        last_pulse = t;
      end
    end
    check("win_first_pulse", 32'(first_pulse), 32'd11);
    check("win_npulses", 32'(npulses), 32'd4);

    // Readout vectors with the consumer always ready.
    for (int i = 0; i < 4; i++) begin
      count_in = rv[i].count; dir_in = rv[i].dir; rd_req = 1'b1; out_ready = 1'b1;
      tick();
      rd_req = 1'b0; count_in = ~rv[i].count;
      check("rd_lo_valid", 32'(out_valid), 32'h1);
      check("rd_lo_data", 32'(out_data), 32'(rv[i].lo));
      check("rd_lo_last", 32'(out_last), 32'h0);
      check("rd_busy", 32'(busy), 32'h1);
      check("rd_snap_dir", 32'(snap_dir), 32'(rv[i].dir));
      tick();
      check("rd_hi_data", 32'(out_data), 32'(rv[i].hi));
      check("rd_hi_last", 32'(out_last), 32'h1);
      tick();
      check("rd_done_valid", 32'(out_valid), 32'h0);
      check("rd_done_busy", 32'(busy), 32'h0);
    end

    // Backpressure: low byte holds while count_in keeps moving.
    count_in = 16'h1234; rd_req = 1'b1; out_ready = 1'b0;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      count_in = count_in + 16'h0111;
      tick();
      check("bp_hold_data", 32'(out_data), 32'h34);
      check("bp_hold_valid", 32'(out_valid), 32'h1);
      check("bp_hold_last", 32'(out_last), 32'h0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_hi_data", 32'(out_data), 32'h12);
    check("bp_hi_last", 32'(out_last), 32'h1);
    tick();
    check("bp_done_busy", 32'(busy), 32'h0);

    // Request in the final handshake cycle is overrun, not a second transfer.
    count_in = 16'hA55A; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    check("ov_in_hi", 32'(out_last), 32'h1);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("ov_set", 32'(overrun), 32'h1);
    check("ov_idle_busy", 32'(busy), 32'h0);
    tick();
    check("ov_no_second", 32'(out_valid), 32'h0);
    ov_clr = 1'b1;
    tick();
    ov_clr = 1'b0;
    check("ov_clr", 32'(overrun), 32'h0);
    rd_req = 1'b1;
    tick();
    check("ov_accept_after", 32'(busy), 32'h1);
    ov_clr = 1'b1;
    tick();
    rd_req = 1'b0; ov_clr = 1'b0;
    check("ov_set_wins", 32'(overrun), 32'h1);
    tick();
    check("ov2_done_busy", 32'(busy), 32'h0);
    ov_clr = 1'b1;
    tick();
    ov_clr = 1'b0;

    // Switch to a window every cycle; takes effect at the next window start.
    period_in = 16'd0;
    wait_vel(12, n);
    check("per0_reload_seen", 32'(n != 0), 32'h1);
    for (int i = 0; i < 6; i++) begin
      count_in = vv[i].count;
      tick();
      if (vv[i].chk) begin
        check("wrap_vel", 32'(vel), 32'(vv[i].exp_vel));
        check("wrap_vel_valid", 32'(vel_valid), 32'h1);
      end
    end

    // Freeze mid-window and mid-transfer.
    period_in = 16'd9;
    tick();
    repeat (3) tick();
    count_in = 16'hBEEF; dir_in = 1'b1; rd_req = 1'b1; out_ready = 1'b0;
    tick();
    rd_req = 1'b0; ena = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      count_in = count_in + 16'd1;
      tick();
      check("frz_data", 32'(out_data), 32'hEF);
      check("frz_valid", 32'(out_valid), 32'h1);
      check("frz_no_vel_valid", 32'(vel_valid), 32'h0);
    end
    ena = 1'b1;
    tick();
    check("frz_resume_hi", 32'(out_data), 32'hBE);
    check("frz_resume_last", 32'(out_last), 32'h1);
    tick();
    check("frz_resume_done", 32'(busy), 32'h0);
    wait_vel(12, n);
    check("frz_window_ticks", 32'(n), 32'd4);
    check("frz_window_vel", 32'(vel), 32'h3F04);

    // Reset in the middle of a transfer drops out_valid without a clock.
    rd_req = 1'b1; out_ready = 1'b0;
    tick();
    rd_req = 1'b0;
    check("arst_pre_valid", 32'(out_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qei_readout_sched.md
Name: qei_readout_sched

Overview:
- Sequencer between the QEI counter core and the host-side 8-bit pins.
- On host request, takes an atomic 16-bit snapshot of the position count and streams it as two bytes (LSB first) over a valid/ready byte port.
- Independently runs a programmable sampling window and reports signed count delta (velocity) per window.
- Sits directly after the quadrature decoder/counter; the core's count and dir are inputs here.

Parameters:
PERIOD_W, 16, width of the velocity window length register/timer

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; 0 freezes timer and FSM, outputs hold
count_in  in  16  live position count from QEI core
dir_in  in  1  live direction from QEI core (1 = forward)
period_in  in  PERIOD_W  window length minus 1, in clk cycles
rd_req  in  1  one-cycle snapshot request pulse
out_ready  in  1  byte consumer ready
ov_clr  in  1  clears overrun flag
out_data  out  8  streamed byte
out_valid  out  1  out_data valid
out_last  out  1  high with final (MSB) byte
busy  out  1  high in any state except IDLE
snap_dir  out  1  dir_in captured with the snapshot
vel  out  16  signed count delta of last completed window
vel_valid  out  1  one-cycle pulse when vel updates
overrun  out  1  sticky: rd_req arrived while busy

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_data, out_valid, out_last, busy, snap_dir, vel, vel_valid, overrun = 0; timer = 0; prev_count = 0; primed = 0. Reset mid-transfer aborts immediately, out_valid drops asynchronously.
- All state advances only when ena=1; with ena=0 every register holds (including pending handshakes).
- Readout FSM: IDLE -> SEND_LO -> SEND_HI -> IDLE.
  - IDLE: rd_req=1 at edge N -> snapshot <= count_in, snap_dir <= dir_in, state SEND_LO. out_valid=1 from cycle N+1 with the count value present at N.
  - SEND_LO: out_data = snapshot[7:0], out_last=0; advance on out_valid & out_ready.
  - SEND_HI: out_data = snapshot[15:8], out_last=1; on handshake -> IDLE. Back-to-back: rd_req in that same handshake cycle is overrun (not accepted); next acceptance earliest the following cycle.
  - out_data/out_last stable while out_valid & !out_ready; no timeout.
  - rd_req while busy: ignored, overrun <= 1. ov_clr=1 clears overrun; ov_clr and new overrun in same cycle -> overrun=1 (set wins).
- Velocity window:
  - timer counts 0..period_q; period_q loaded from period_in at each window start (change mid-window has no effect until next window). period_in=0 -> window every cycle.
  - At terminal count: vel <= count_in - prev_count (16-bit modulo, two's complement), prev_count <= count_in, timer <= 0.
  - First window after reset only primes prev_count (primed <= 1); vel and vel_valid unchanged. Later windows pulse vel_valid for exactly one cycle.
  - Wrap: prev 0xFFFE, now 0x0003 -> vel=+5; prev 0x0003, now 0xFFFE -> vel=-5 (0xFFFB).
- Snapshot capture and window terminal in same cycle: both use the same count_in sample; independent, no priority needed.

Optional Feature:
QEI_VEL_SAT_EN
- Defined: vel computed as 17-bit signed difference of sign-extended counts then saturated to 16-bit signed; a sat_flag (sticky, cleared by ov_clr) is added. Intended when count_in is treated as signed position.
- Undefined: vel is plain 16-bit modulo difference, no saturation logic, no sat_flag port.

Test Plan:
- Reset, count_in=0x1234, rd_req pulse, out_ready=1 -> cycle+1 out_valid=1 out_data=0x34 out_last=0; next 0x12 out_last=1; then busy=0.
- Backpressure: out_ready=0 for 5 cycles after rd_req, count_in changing -> out_data holds 0x34, snapshot unchanged; release -> 0x34 then 0x12.
- rd_req during SEND_HI -> overrun=1, no second transfer; ov_clr pulse -> overrun=0.
- period_in=9, count_in +1 per cycle -> first window no vel_valid; subsequent vel_valid every 10 cycles, vel=10.
- Wrap: window prev 0xFFFE -> 0x0003 gives vel=0x0005; reverse gives 0xFFFB.
- ena=0 for 20 cycles mid-window and mid-transfer -> no vel_valid, out_data/state frozen; resumes correctly on ena=1.
